// File: rtl/iccm_arb_pkg.sv
// Shared types for the ICCM port arbiter: FSM states and response ownership.
package iccm_arb_pkg;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DRAIN} arb_state_e;

  typedef enum logic {OWN_F, OWN_H} arb_own_e;

endpackage

// File: rtl/iccm_resp_router.sv
// Tracks the one outstanding ICCM response and steers rvalid/rdata (or a host
// write ack) back to the requester that was granted the previous cycle.
module iccm_resp_router
  import iccm_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  f_gnt_i,
  input  logic                  h_gnt_i,
  input  logic                  h_we_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  pend_f_o,
  output logic                  f_rvalid_o,
  output logic [DATA_WIDTH-1:0] f_rdata_o,
  output logic                  h_rvalid_o,
  output logic [DATA_WIDTH-1:0] h_rdata_o
);

  logic     pend_vld_q;
  arb_own_e pend_own_q;
  logic     wack_q;
  logic     rsp_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_vld_q <= 1'b0;
      pend_own_q <= OWN_F;
      wack_q     <= 1'b0;
    end else begin
      pend_vld_q <= (f_gnt_i | h_gnt_i) & ~(h_gnt_i & h_we_i);
      pend_own_q <= h_gnt_i ? OWN_H : OWN_F;
      wack_q     <= h_gnt_i & h_we_i;
    end
  end

  // Responses landing in a reset cycle belong to a discarded request.
  always_comb begin
    rsp_ok     = pend_vld_q & mem_rvalid_i & ~rst_i;
    pend_f_o   = pend_vld_q & (pend_own_q == OWN_F);
    f_rvalid_o = rsp_ok & (pend_own_q == OWN_F);
    f_rdata_o  = f_rvalid_o ? mem_rdata_i : '0;
    h_rvalid_o = (wack_q & ~rst_i) | (rsp_ok & (pend_own_q == OWN_H));
    h_rdata_o  = (rsp_ok & (pend_own_q == OWN_H)) ? mem_rdata_i : '0;
  end

endmodule

// File: rtl/iccm_port_arbiter.sv
// Shares the single-port ICCM between core fetch and host/loader, sequencing
// boot (host-only) -> run (core enabled) -> drain -> boot on reload.
module iccm_port_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4,
  parameter bit          BOOT_EN    = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_done_i,
  input  logic                    reload_i,
  output logic                    core_en_o,
  input  logic                    f_req_i,
  input  logic [ADDR_WIDTH-1:0]   f_addr_i,
  output logic                    f_gnt_o,
  output logic                    f_rvalid_o,
  output logic [DATA_WIDTH-1:0]   f_rdata_o,
  input  logic                    h_req_i,
  input  logic                    h_we_i,
  input  logic [ADDR_WIDTH-1:0]   h_addr_i,
  input  logic [DATA_WIDTH-1:0]   h_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] h_wmask_i,
  output logic                    h_gnt_o,
  output logic                    h_rvalid_o,
  output logic [DATA_WIDTH-1:0]   h_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_rvalid_i
);

  localparam int unsigned WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
  localparam arb_state_e RESET_ST = BOOT_EN ? ST_BOOT : ST_RUN;

  arb_state_e     state_q;
  logic           core_en_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           host_first;
  logic           pend_f;

  always_comb begin
    f_gnt_o    = 1'b0;
    h_gnt_o    = 1'b0;
    host_first = (wait_cnt_q == WAIT_MAX);
    if (!rst_i) begin
      unique case (state_q)
        ST_BOOT: h_gnt_o = h_req_i;
        ST_RUN: begin
          h_gnt_o = h_req_i & (host_first | ~f_req_i);
          f_gnt_o = f_req_i & ~h_gnt_o;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = f_gnt_o | h_gnt_o;
    mem_we_o    = h_gnt_o & h_we_i;
    mem_addr_o  = h_gnt_o ? h_addr_i : f_addr_i;
    mem_wdata_o = h_gnt_o ? h_wdata_i : '0;
    mem_wmask_o = h_gnt_o ? h_wmask_i : '0;
    core_en_o   = core_en_q;
  end

  // A fetch granted on the reload cycle is the only response left in flight,
  // so DRAIN is entered exactly when that grant happens.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RESET_ST;
      core_en_q  <= !BOOT_EN;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          if (load_done_i) begin
            state_q   <= ST_RUN;
            core_en_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (reload_i) begin
            state_q   <= f_gnt_o ? ST_DRAIN : ST_BOOT;
            core_en_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (mem_rvalid_i | ~pend_f) state_q <= ST_BOOT;
        end
        default: begin
          state_q   <= ST_BOOT;
          core_en_q <= 1'b0;
        end
      endcase

      if (h_gnt_o) wait_cnt_q <= '0;
      else if (h_req_i && wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  iccm_resp_router #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_router (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .f_gnt_i     (f_gnt_o),
    .h_gnt_i     (h_gnt_o),
    .h_we_i      (h_we_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .pend_f_o    (pend_f),
    .f_rvalid_o  (f_rvalid_o),
    .f_rdata_o   (f_rdata_o),
    .h_rvalid_o  (h_rvalid_o),
    .h_rdata_o   (h_rdata_o)
  );

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed bench for iccm_port_arbiter with a 1-cycle SRAM model and a
// response scoreboard popped by an independent monitor.
module tb_iccm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_done, reload, core_en;
  logic        f_req, f_gnt, f_rvalid;
  logic [11:0] f_addr;
  logic [31:0] f_rdata;
  logic        h_req, h_we, h_gnt, h_rvalid;
  logic [11:0] h_addr;
  logic [31:0] h_wdata, h_rdata;
  logic [3:0]  h_wmask;
  logic        mem_req, mem_we, mem_rvalid;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  typedef struct {
    bit          own_h;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sram [0:4095];

  always #5 clk = ~clk;

  iccm_port_arbiter #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .MAX_WAIT  (4),
    .BOOT_EN   (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_done_i (load_done),
    .reload_i    (reload),
    .core_en_o   (core_en),
    .f_req_i     (f_req),
    .f_addr_i    (f_addr),
    .f_gnt_o     (f_gnt),
    .f_rvalid_o  (f_rvalid),
    .f_rdata_o   (f_rdata),
    .h_req_i     (h_req),
    .h_we_i      (h_we),
    .h_addr_i    (h_addr),
    .h_wdata_i   (h_wdata),
    .h_wmask_i   (h_wmask),
    .h_gnt_o     (h_gnt),
    .h_rvalid_o  (h_rvalid),
    .h_rdata_o   (h_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wmask_o (mem_wmask),
    .mem_rdata_i (mem_rdata),
    .mem_rvalid_i(mem_rvalid)
  );

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  end

  always @(posedge clk) begin
    mem_rvalid <= mem_req & ~mem_we;
    if (mem_req && !mem_we) mem_rdata <= sram[mem_addr];
    if (mem_req && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (f_rvalid || h_rvalid) begin
      rsp_t e;
      chk("rvalid_onehot", {31'd0, f_rvalid & h_rvalid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, f_rvalid, h_rvalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_owner", {31'd0, h_rvalid}, {31'd0, e.own_h});
        chk("rsp_data", h_rvalid ? h_rdata : f_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(bit own_h, logic [31:0] d);
    rsp_t e;
    e.own_h = own_h;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; load_done = 0; reload = 0;
    f_req = 1; f_addr = 12'h010;
    h_req = 1; h_we = 0; h_addr = '0; h_wdata = '0; h_wmask = '0;
    step(); step();
    @(negedge clk);
    chk("rst_f_gnt", {31'd0, f_gnt}, 0);
    chk("rst_h_gnt", {31'd0, h_gnt}, 0);
    chk("rst_core_en", {31'd0, core_en}, 0);
    chk("rst_rvalid", {30'd0, f_rvalid, h_rvalid}, 0);

    // Boot: host write then read while fetch is held off
    step(); rst = 0;
    h_req = 1; h_we = 1; h_addr = 12'h010; h_wdata = 32'hDEADBEEF; h_wmask = 4'hF;
    @(negedge clk);
    chk("boot_h_gnt_wr", {31'd0, h_gnt}, 1);
    chk("boot_f_gnt", {31'd0, f_gnt}, 0);
    chk("boot_mem_we", {31'd0, mem_we}, 1);
    chk("boot_mem_addr", {20'd0, mem_addr}, 32'h010);
    chk("boot_core_en", {31'd0, core_en}, 0);
    push(1, 32'h0);
    step(); h_we = 0;
    @(negedge clk);
    chk("boot_h_gnt_rd", {31'd0, h_gnt}, 1);
    chk("boot_f_gnt_rd", {31'd0, f_gnt}, 0);
    push(1, 32'hDEADBEEF);
    step(); h_req = 0; f_req = 0; load_done = 1;
    @(negedge clk);
    chk("boot_core_en_ld", {31'd0, core_en}, 0);

    // RUN: fetch of the loaded word
    step(); load_done = 0; f_req = 1;
    @(negedge clk);
    chk("run_core_en", {31'd0, core_en}, 1);
    chk("run_f_gnt", {31'd0, f_gnt}, 1);
    push(0, 32'hDEADBEEF);
    step(); f_req = 0;
    @(negedge clk);
    chk("run_h_rvalid_quiet", {31'd0, h_rvalid}, 0);

    // Starvation: host wins exactly every 5th cycle
    step(); f_req = 1; h_req = 1; h_we = 0; h_addr = 12'h010;
    for (int i = 0; i < 10; i++) begin
      bit hw;
      hw = (i == 4) || (i == 9);
      @(negedge clk);
      chk("starve_h_gnt", {31'd0, h_gnt}, {31'd0, hw});
      chk("starve_f_gnt", {31'd0, f_gnt}, {31'd0, !hw});
      push(hw, 32'hDEADBEEF);
      step();
    end

    // Interleave: fetch read, host masked write, fetch read, host read
    f_req = 1; f_addr = 12'h010; h_req = 0;
    @(negedge clk);
    chk("il_f_gnt0", {31'd0, f_gnt}, 1);
    push(0, 32'hDEADBEEF);
    step(); f_req = 0; h_req = 1; h_we = 1; h_addr = 12'h020;
    h_wdata = 32'h12345678; h_wmask = 4'h3;
    @(negedge clk);
    chk("il_h_gnt", {31'd0, h_gnt}, 1);
    push(1, 32'h0);
    step(); h_req = 0; h_we = 0; f_req = 1; f_addr = 12'h020;
    @(negedge clk);
    chk("il_f_gnt1", {31'd0, f_gnt}, 1);
    push(0, 32'h00005678);
    step(); f_req = 0; h_req = 1;
    @(negedge clk);
    chk("il_h_gnt_rd", {31'd0, h_gnt}, 1);
    push(1, 32'h00005678);

    // Reload with a fetch granted on the same cycle -> DRAIN -> BOOT
    step(); h_req = 0; f_req = 1; f_addr = 12'h010; reload = 1;
    @(negedge clk);
    chk("rl_f_gnt", {31'd0, f_gnt}, 1);
    chk("rl_core_en", {31'd0, core_en}, 1);
    push(0, 32'hDEADBEEF);
    step(); reload = 0; h_req = 1; h_addr = 12'h020;
    @(negedge clk);
    chk("drain_mem_req", {31'd0, mem_req}, 0);
    chk("drain_core_en", {31'd0, core_en}, 0);
    step();
    @(negedge clk);
    chk("rb_h_gnt", {31'd0, h_gnt}, 1);
    chk("rb_f_gnt", {31'd0, f_gnt}, 0);
    chk("rb_core_en", {31'd0, core_en}, 0);

    // Reset the cycle after a host read grant: response discarded
    step(); rst = 1; h_req = 0; f_req = 0;
    @(negedge clk);
    chk("mrst_h_rvalid", {31'd0, h_rvalid}, 0);
    chk("mrst_core_en", {31'd0, core_en}, 0);
    step(); rst = 0; h_req = 1; f_req = 1;
    @(negedge clk);
    chk("post_rst_h_gnt", {31'd0, h_gnt}, 1);
    chk("post_rst_f_gnt", {31'd0, f_gnt}, 0);
    chk("post_rst_rvalid", {30'd0, f_rvalid, h_rvalid}, 0);
    push(1, 32'h00005678);

    // load_done wins over reload in BOOT; reload with nothing in flight -> BOOT
    step(); h_req = 0; f_req = 0; load_done = 1; reload = 1;
    step(); load_done = 0; reload = 0;
    @(negedge clk);
    chk("ld_wins_core_en", {31'd0, core_en}, 1);
    step(); reload = 1;
    step(); reload = 0; h_req = 1; h_addr = 12'h010; f_req = 1;
    @(negedge clk);
    chk("rl_direct_core_en", {31'd0, core_en}, 0);
    chk("rl_direct_h_gnt", {31'd0, h_gnt}, 1);
    chk("rl_direct_f_gnt", {31'd0, f_gnt}, 0);
    push(1, 32'hDEADBEEF);
    step(); h_req = 0; f_req = 0;

    for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
